blctrl_i2c_responder: RTL

I2C slave that emulates a bank of BL-Ctrl ESCs: the receiving end of the bus driven by blctrlHandler.
- Decodes write transactions to NUM_MOTORS consecutive 7-bit addresses and latches one 8-bit target speed per motor.
- Answers read transactions with per-motor status bytes.
- Used as an in-FPGA ESC model for closed-loop bench tests and as a bridge that converts I2C speed commands into the DShot path.

---
 rtl/blctrl_pkg.sv | 33 +++
 rtl/blctrl_i2c_responder_if.sv | 10 +
 rtl/i2c_line_filter.sv | 44 ++++
 rtl/blctrl_i2c_responder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/blctrl_pkg.sv
// Shared definitions for the BL-Ctrl I2C responder and its bus master counterpart.
package blctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } state_t;

  localparam logic [1:0] STATUS_SEL_CURRENT = 2'd0;
  localparam logic [1:0] STATUS_SEL_STATUS  = 2'd1;
  localparam logic [1:0] STATUS_SEL_TEMP    = 2'd2;

  localparam logic [6:0] ADDR_BASE_DEFAULT = 7'h29;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // Status word layout is {temp, status, current}.
  function automatic logic [7:0] status_byte(input logic [23:0] word, input logic [1:0] sel);
    case (sel)
      STATUS_SEL_STATUS: return word[15:8];
      STATUS_SEL_TEMP:   return word[23:16];
      default:           return word[7:0];
    endcase
  endfunction

endpackage

// File: rtl/blctrl_i2c_responder_if.sv
// I2C pad-side signals of the BL-Ctrl responder (open-drain SDA via sda_t).
interface blctrl_i2c_responder_if;
  logic scl_i;
  logic sda_i;
  logic sda_o;
  logic sda_t;

  modport master (output scl_i, sda_i, input sda_o, sda_t);
  modport slave  (input scl_i, sda_i, output sda_o, sda_t);
endinterface

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus FILTER_LEN-sample glitch filter with registered edge strobes.
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Idle I2C lines are high, so everything resets to 1 to avoid a fake edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      sync <= {sync[0], pad};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= sync[1];
        cnt   <= '0;
        rise  <= sync[1];
        fall  <= ~sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/blctrl_i2c_responder.sv
// I2C slave emulating NUM_MOTORS BL-Ctrl ESCs: latches speeds, returns status bytes.
// Optional BLCTRL_TIMEOUT_EN zeroes all speeds after TIMEOUT_CYCLES without a write.
module blctrl_i2c_responder
  import blctrl_pkg::*;
#(
  parameter logic [6:0]  ADDR_BASE      = ADDR_BASE_DEFAULT,
  parameter int          NUM_MOTORS     = 8,
  parameter int          FILTER_LEN     = 3,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd8_000_000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  blctrl_i2c_responder_if.slave     bus,
  output logic [8*NUM_MOTORS-1:0]   speedFlat,
  output logic                      speed_valid,
  output logic [3:0]                speed_idx,
  input  logic [24*NUM_MOTORS-1:0]  statusFlat,
  output logic                      busy
);

  if (NUM_MOTORS < 1 || NUM_MOTORS > 16 || TIMEOUT_CYCLES == 32'd0) begin : g_bad_cfg
    $error("blctrl_i2c_responder: unsupported configuration");
  end

  logic scl_level, scl_rise, scl_fall;
  logic sda_level, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk(clk), .rst_n(rst_n), .pad(bus.scl_i),
    .level(scl_level), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk(clk), .rst_n(rst_n), .pad(bus.sda_i),
    .level(sda_level), .rise(sda_rise), .fall(sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = sda_fall & scl_level;
  assign stop_det  = sda_rise & scl_level;

  state_t     state;
  logic [7:0] shift, tx;
  logic [2:0] bit_cnt;
  logic [3:0] idx;
  logic [1:0] sel;
  logic       rd, first_byte, ack_phase, sda_t_q;
  logic [7:0] speed_q [NUM_MOTORS];

  // Unsigned 7-bit wrap makes addresses below ADDR_BASE land far out of range.
  logic [6:0] addr_off;
  logic       addr_hit;
  assign addr_off = shift[7:1] - ADDR_BASE;
  assign addr_hit = ({25'd0, addr_off} < NUM_MOTORS);

  logic [23:0] status_word;
  logic [7:0]  tx_next;
  always_comb begin
    // NOTE: default first so no path leaves status_word unassigned (no latch).
    status_word = '0;
    for (int k = 0; k < NUM_MOTORS; k++)
      if (idx == 4'(k)) status_word = statusFlat[24*k +: 24];
  end
  assign tx_next = status_byte(status_word, sel);

`ifdef BLCTRL_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        tmo_armed;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      shift      <= '0;
      tx         <= '0;
      bit_cnt    <= '0;
      idx        <= '0;
      sel        <= STATUS_SEL_CURRENT;
      rd         <= 1'b0;
      first_byte <= 1'b0;
      ack_phase  <= 1'b0;
      sda_t_q    <= I2C_NACK;
      busy       <= 1'b0;
      speed_valid <= 1'b0;
      speed_idx  <= '0;
      // NOTE: the speed bank is architectural output state, so it is reset explicitly.
      for (int k = 0; k < NUM_MOTORS; k++) speed_q[k] <= '0;
`ifdef BLCTRL_TIMEOUT_EN
      tmo_cnt    <= '0;
      tmo_armed  <= 1'b0;
`endif
    end else begin
      speed_valid <= 1'b0;

`ifdef BLCTRL_TIMEOUT_EN
      // A write later in this block overrides the timeout on a coinciding cycle.
      if (tmo_armed) begin
        if (tmo_cnt == TIMEOUT_CYCLES) begin
          for (int k = 0; k < NUM_MOTORS; k++) speed_q[k] <= '0;
          speed_valid <= 1'b1;
          speed_idx   <= 4'hF;
          tmo_armed   <= 1'b0;
        end else begin
          tmo_cnt <= tmo_cnt + 32'd1;
        end
      end
`endif

      if (start_det) begin
        state     <= ST_ADDR;
        bit_cnt   <= '0;
        ack_phase <= 1'b0;
        sda_t_q   <= I2C_NACK;
        busy      <= 1'b1;
      end else if (stop_det) begin
        state   <= ST_IDLE;
        sda_t_q <= I2C_NACK;
        busy    <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: if (scl_rise) begin
            shift   <= {shift[6:0], sda_level};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state     <= ST_ADDR_ACK;
              ack_phase <= 1'b0;
            end
          end

          ST_ADDR_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              if (addr_hit) begin
                sda_t_q    <= I2C_ACK;
                ack_phase  <= 1'b1;
                idx        <= addr_off[3:0];
                rd         <= shift[0];
                sel        <= STATUS_SEL_CURRENT;
                first_byte <= 1'b1;
              end else begin
                state <= ST_IGNORE;
              end
            end else begin
              ack_phase <= 1'b0;
              bit_cnt   <= '0;
              if (rd) begin
                sda_t_q <= tx_next[7];
                tx      <= {tx_next[6:0], 1'b1};
                state   <= ST_RD_DATA;
              end else begin
                sda_t_q <= I2C_NACK;
                state   <= ST_WR_DATA;
              end
            end
          end

          ST_WR_DATA: if (scl_rise) begin
            shift   <= {shift[6:0], sda_level};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state     <= ST_WR_ACK;
              ack_phase <= 1'b0;
              if (first_byte) begin
                for (int k = 0; k < NUM_MOTORS; k++)
                  if (idx == 4'(k)) speed_q[k] <= {shift[6:0], sda_level};
                speed_valid <= 1'b1;
                speed_idx   <= idx;
`ifdef BLCTRL_TIMEOUT_EN
                tmo_cnt   <= '0;
                tmo_armed <= 1'b1;
`endif
              end
            end
          end

          // Only the first data byte of a write is accepted.
          ST_WR_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              if (first_byte) begin
                sda_t_q   <= I2C_ACK;
                ack_phase <= 1'b1;
              end else begin
                state <= ST_IGNORE;
              end
            end else begin
              sda_t_q    <= I2C_NACK;
              ack_phase  <= 1'b0;
              first_byte <= 1'b0;
              bit_cnt    <= '0;
              state      <= ST_WR_DATA;
            end
          end

          ST_RD_DATA: begin
            if (scl_fall) begin
              sda_t_q <= tx[7];
              tx      <= {tx[6:0], 1'b1};
            end
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state     <= ST_RD_ACK;
                ack_phase <= 1'b0;
              end
            end
          end

          // ack_phase marks that the master ACKed and the next byte loads at the fall.
          ST_RD_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_t_q <= I2C_NACK;
              end else begin
                sda_t_q   <= tx_next[7];
                tx        <= {tx_next[6:0], 1'b1};
                ack_phase <= 1'b0;
                bit_cnt   <= '0;
                state     <= ST_RD_DATA;
              end
            end
            if (scl_rise) begin
              if (sda_level == I2C_ACK) begin
                ack_phase <= 1'b1;
                sel <= (sel == STATUS_SEL_TEMP) ? STATUS_SEL_CURRENT : sel + 2'd1;
              end else begin
                state <= ST_IGNORE;
              end
            end
          end

          default: ;
        endcase
      end
    end
  end

  assign bus.sda_o = 1'b0;
  assign bus.sda_t = sda_t_q;

  for (genvar k = 0; k < NUM_MOTORS; k++) begin : g_speed_flat
    assign speedFlat[8*k +: 8] = speed_q[k];
  end

endmodule
